stopwatch_ctrl: RTL

Stopwatch/game-timer controller for the DE0 board that sequences the 100 Hz / 1 Hz clock generator. It drives the generator's enable and clear inputs and counts its 100 Hz output into a 4-digit BCD SS.hh value. It sits between the debounced pushbuttons and the seven-segment display driver and adds run/stop, lap-freeze, clear and overflow handling.

---
 rtl/stopwatch_pkg.sv | 42 ++++
 rtl/sync_edge_det.sv | 37 +++
 rtl/stopwatch_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller.
//   - state_e  : controller state encoding (3 bits)
//   - BCD_W    : width of one BCD digit
//   - NDIG     : number of BCD digits in the count
//   - BCD_MAX  : largest value of a BCD digit
//   - bcd_inc  : increment a NDIG-digit BCD value by one, with digit carry
package stopwatch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    RUN  = 3'd2,
    LAP  = 3'd3,
    STOP = 3'd4,
    DONE = 3'd5
  } state_e;

  localparam int          BCD_W   = 4;
  localparam int          NDIG    = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  // Each digit rolls 9 -> 0 and carries into the next; the top digit
  // wraps silently (saturation is handled by the caller).
  function automatic logic [NDIG*BCD_W-1:0] bcd_inc(input logic [NDIG*BCD_W-1:0] v);
    logic [NDIG*BCD_W-1:0] r;
    logic                  carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (carry) begin
        if (v[i*BCD_W +: BCD_W] == BCD_MAX) begin
          r[i*BCD_W +: BCD_W] = '0;
        end else begin
          r[i*BCD_W +: BCD_W] = v[i*BCD_W +: BCD_W] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Input synchronizer followed by a rising-edge detector.
//   clk   : sampling clock
//   rst   : synchronous active-high reset
//   din   : asynchronous / external level input
//   pulse : one-cycle high pulse on each rising edge of din
// All flops reset to 1 so a level held high through reset is not seen
// as an edge when reset is released.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: sequences the 100 Hz / 1 Hz clock generator and
// counts its 100 Hz output as a 4-digit BCD SS.hh value.
//   ClkIn     : system clock, rising edge
//   Clr       : synchronous active-high reset
//   StartStop : debounced button, rising edge = start/stop
//   LapReset  : debounced button, rising edge = lap/reset
//   Clk100    : 100 Hz pulse from generator (asynchronous)
//   GenEn     : generator enable
//   GenEn1    : generator 1 Hz-stage enable
//   GenClr_   : generator clear, active-low
//   Digits    : BCD display value {tens s, s, tenths, hundredths}
//   Running   : high in RUN and LAP
//   Frozen    : high in LAP (Digits shows the lap latch)
//   Ovf       : high in DONE
// Every output is a flop loaded from next-state values, so there is no
// combinational path from any input to any output.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter bit          USE_1HZ     = 1'b1,
  parameter logic [15:0] SAT_VALUE   = 16'h9999
) (
  input  logic        ClkIn,
  input  logic        Clr,
  input  logic        StartStop,
  input  logic        LapReset,
  input  logic        Clk100,
  output logic        GenEn,
  output logic        GenEn1,
  output logic        GenClr_,
  output logic [15:0] Digits,
  output logic        Running,
  output logic        Frozen,
  output logic        Ovf
);

  logic ev_ss, ev_lr, tick;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
    .clk(ClkIn), .rst(Clr), .din(StartStop), .pulse(ev_ss)
  );
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_lr (
    .clk(ClkIn), .rst(Clr), .din(LapReset), .pulse(ev_lr)
  );
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_tk (
    .clk(ClkIn), .rst(Clr), .din(Clk100), .pulse(tick)
  );

  state_e                state_q, state_d;
  logic [NDIG*BCD_W-1:0] count_q, count_d;
  logic [NDIG*BCD_W-1:0] lap_q, lap_d;
  logic [15:0]           digits_q, digits_d;
  logic                  gen_en_q, gen_en_d;
  logic                  gen_en1_q, gen_en1_d;
  logic                  gen_clr_n_q, gen_clr_n_d;
  logic                  running_q, running_d;
  logic                  frozen_q, frozen_d;
  logic                  ovf_q, ovf_d;

  // State, count and output registers
  always_ff @(posedge ClkIn) begin
    if (Clr) begin
      state_q     <= IDLE;
      count_q     <= '0;
      lap_q       <= '0;
      digits_q    <= '0;
      gen_en_q    <= 1'b0;
      gen_en1_q   <= 1'b0;
      gen_clr_n_q <= 1'b0;
      running_q   <= 1'b0;
      frozen_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      lap_q       <= lap_d;
      digits_q    <= digits_d;
      gen_en_q    <= gen_en_d;
      gen_en1_q   <= gen_en1_d;
      gen_clr_n_q <= gen_clr_n_d;
      running_q   <= running_d;
      frozen_q    <= frozen_d;
      ovf_q       <= ovf_d;
    end
  end

  // Next state. In RUN/LAP the tick is applied first so an exit event in
  // the same cycle sees the updated count; a saturating tick wins over
  // any button event because DONE is terminal until lap/reset.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lap_d   = lap_q;
    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (ev_ss) state_d = ARM;
      end
      ARM: state_d = RUN;
      RUN, LAP: begin
        if (tick && count_q == SAT_VALUE) begin
          state_d = DONE;
        end else begin
          if (tick) count_d = bcd_inc(count_q);
          if (ev_ss) begin
            state_d = STOP;
          end else if (ev_lr) begin
            if (state_q == RUN) begin
              lap_d   = count_d;
              state_d = LAP;
            end else begin
              state_d = RUN;
            end
          end
        end
      end
      STOP: begin
        if (ev_ss) begin
          state_d = RUN;
        end else if (ev_lr) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      DONE: begin
        if (ev_lr) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so they register with it.
  always_comb begin
    gen_clr_n_d = (state_d != IDLE);
    gen_en_d    = (state_d == RUN) || (state_d == LAP);
    gen_en1_d   = USE_1HZ ? gen_en_d : 1'b0;
    running_d   = gen_en_d;
    frozen_d    = (state_d == LAP);
    ovf_d       = (state_d == DONE);
    if (state_d == LAP)       digits_d = lap_d;
    else if (state_d == DONE) digits_d = SAT_VALUE;
    else                      digits_d = count_d;
  end

  assign GenEn   = gen_en_q;
  assign GenEn1  = gen_en1_q;
  assign GenClr_ = gen_clr_n_q;
  assign Digits  = digits_q;
  assign Running = running_q;
  assign Frozen  = frozen_q;
  assign Ovf     = ovf_q;

endmodule
